// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and parameter defaults for the clock divider controller
package clk_div_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int DEF_HALF_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter and output toggle; clr dominates and parks the output low
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  input  logic             clr,
  output logic             out_clk,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_clk_q, out_clk_d;

  // half is never zero, so half-1 cannot underflow
  always_comb boundary = run && (cnt_q == (half - CNT_W'(1)));

  always_comb begin
    cnt_d     = cnt_q;
    out_clk_d = out_clk_q;
    if (clr) begin
      cnt_d     = '0;
      out_clk_d = 1'b0;
    end else if (boundary) begin
      cnt_d     = '0;
      out_clk_d = ~out_clk_q;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    out_clk_q <= out_clk_d;
  end

  assign out_clk = out_clk_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - start/stop FSM and glitch-free half-period reload; CLK_DIV_CTRL_EDGE_CNT_EN adds edge_cnt
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             out_clk,
  output logic             edge_pulse,
  output logic             busy
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
  ,
  output logic [15:0]      edge_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] half_reg_q, half_reg_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             edge_pulse_q, edge_pulse_d;
  logic             core_run, core_clr, core_out, boundary;
  logic             accept, apply;

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .run      (core_run),
    .half     (half_reg_q),
    .clr      (core_clr),
    .out_clk  (core_out),
    .boundary (boundary)
  );

  // Stopping during a low phase ends at once; a high phase must finish first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = (!core_out || boundary) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en) state_d = ST_RUN;
        else if (boundary) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core_run = (state_q != ST_IDLE);
    core_clr = reset || (state_d == ST_IDLE);
    accept   = cfg_valid && cfg_ready_q;
    apply    = pend_v_q && ((state_q == ST_IDLE) || boundary);
  end

  always_comb begin
    half_reg_d   = apply ? pend_q : half_reg_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    cfg_ready_d  = cfg_ready_q;
    // a truncated low phase reaches its boundary without toggling
    edge_pulse_d = boundary && ((state_d != ST_IDLE) || core_out);
    if (apply) begin
      pend_v_d    = 1'b0;
      cfg_ready_d = 1'b1;
    end
    if (accept) begin
      pend_d      = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
      pend_v_d    = 1'b1;
      cfg_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      half_reg_q   <= CNT_W'(DEF_HALF);
      pend_q       <= CNT_W'(DEF_HALF);
      pend_v_q     <= 1'b0;
      cfg_ready_q  <= 1'b1;
      edge_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_reg_q   <= half_reg_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      cfg_ready_q  <= cfg_ready_d;
      edge_pulse_q <= edge_pulse_d;
    end
  end

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
  logic [15:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (edge_pulse_d && !core_out) edge_cnt_d = edge_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) edge_cnt_q <= 16'd0;
    else       edge_cnt_q <= edge_cnt_d;
  end

  assign edge_cnt = edge_cnt_q;
`endif

  assign cfg_ready  = cfg_ready_q;
  assign out_clk    = core_out;
  assign edge_pulse = edge_pulse_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - vector table, corner sequences and randomized run against a phase-countdown model
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset, en, cfg_valid;
  logic [7:0] cfg_half;
  logic       cfg_ready, out_clk, edge_pulse, busy;
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
  logic [15:0] edge_cnt;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_half   (cfg_half),
    .cfg_ready  (cfg_ready),
    .out_clk    (out_clk),
    .edge_pulse (edge_pulse),
    .busy       (busy)
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    .edge_cnt   (edge_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // model: 0 stopped, 1 running, 2 finishing a high phase
  int m_st, m_lvl, m_left, m_half, m_pend, m_pv, m_ready, m_pulse, m_edges;

  typedef struct {
    int en; int cv; int ch; int rst;
    int o;  int p;  int b;  int r;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int e, input int cv, input int ch, input int rst);
    int bnd, acc, app, nh, nlvl, pulse;
    if (rst != 0) begin
      m_st = 0; m_lvl = 0; m_left = 0; m_half = 5; m_pend = 0;
      m_pv = 0; m_ready = 1; m_pulse = 0; m_edges = 0;
      return;
    end
    bnd   = (m_st != 0 && m_left == 1) ? 1 : 0;
    acc   = (cv != 0 && m_ready != 0) ? 1 : 0;
    app   = (m_pv != 0 && (m_st == 0 || bnd != 0)) ? 1 : 0;
    nh    = (app != 0) ? m_pend : m_half;
    pulse = 0;
    nlvl  = m_lvl;
    if (m_st == 0) begin
      if (e != 0) begin
        m_st   = 1;
        m_left = nh;
      end
      nlvl = 0;
    end else if (e == 0 && ((m_st == 2) ? (bnd != 0) : (m_lvl == 0 || bnd != 0))) begin
      pulse = (bnd != 0 && m_lvl != 0) ? 1 : 0;
      nlvl  = 0;
      m_st  = 0;
    end else begin
      if (bnd != 0) begin
        nlvl   = (m_lvl != 0) ? 0 : 1;
        pulse  = 1;
        m_left = nh;
      end else begin
        m_left = m_left - 1;
      end
      m_st = (e != 0) ? 1 : 2;
    end
    if (pulse != 0 && nlvl != 0) m_edges = (m_edges + 1) & 32'hFFFF;
    m_lvl   = nlvl;
    m_pulse = pulse;
    m_half  = nh;
    if (app != 0) begin
      m_pv    = 0;
      m_ready = 1;
    end
    if (acc != 0) begin
      m_pend  = (ch == 0) ? 1 : ch;
      m_pv    = 1;
      m_ready = 0;
    end
  endtask

  task automatic tick(input int e, input int cv, input int ch, input int rst);
    logic [31:0] chv;
    chv       = ch;
    en        = (e != 0);
    cfg_valid = (cv != 0);
    cfg_half  = chv[7:0];
    reset     = (rst != 0);
    model_step(e, cv, ch, rst);
    @(posedge clk);
    @(negedge clk);
    chk("model_out_clk", out_clk, m_lvl);
    chk("model_edge_pulse", edge_pulse, m_pulse);
    chk("model_busy", busy, (m_st != 0) ? 1 : 0);
    chk("model_cfg_ready", cfg_ready, m_ready);
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    chk("model_edge_cnt", edge_cnt, m_edges);
`endif
  endtask

  // ticks with en=1 until the next toggle; result is the phase length
  task automatic run_phase(output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      tick(1, 0, 0, 0);
      n++;
      if (edge_pulse === 1'b1) break;
    end
  endtask

  initial begin
    int n;
    int e_r;
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;

    tbl[0]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 0, 0, 0, 1, 1, 1, 1};
    tbl[7]  = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[8]  = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[10] = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[16] = '{1, 0, 0, 0, 1, 1, 1, 1};
    tbl[17] = '{1, 0, 0, 0, 0, 1, 1, 1};
    tbl[18] = '{1, 0, 0, 0, 1, 1, 1, 1};

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].en, tbl[i].cv, tbl[i].ch, tbl[i].rst);
      chk($sformatf("tbl%0d_out_clk", i), out_clk, tbl[i].o);
      chk($sformatf("tbl%0d_edge_pulse", i), edge_pulse, tbl[i].p);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("tbl%0d_cfg_ready", i), cfg_ready, tbl[i].r);
    end

    // reload to 3 offered mid high phase
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 0);
    run_phase(n);
    chk("first_rise_delay", n, 5);
    chk("first_rise_level", out_clk, 1);
    tick(1, 1, 3, 0);
    chk("reload_ready_low", cfg_ready, 0);
    run_phase(n);
    chk("reload_old_phase_rest", n, 4);
    chk("reload_ready_back", cfg_ready, 1);
    run_phase(n);
    chk("reload_phase_a", n, 3);
    run_phase(n);
    chk("reload_phase_b", n, 3);

    // stop during high phase, then during low phase
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 0);
    run_phase(n);
    tick(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 0);
      chk("drain_holds_high", out_clk, 1);
    end
    tick(0, 0, 0, 0);
    chk("drain_falls", out_clk, 0);
    chk("drain_idle", busy, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("low_stop_idle", busy, 0);
    chk("low_stop_level", out_clk, 0);

    // reset with a pending reload discards it
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 0);
    run_phase(n);
    tick(1, 1, 7, 0);
    tick(1, 0, 0, 1);
    chk("rst_mid_out", out_clk, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cfg_ready, 1);
    tick(1, 0, 0, 0);
    run_phase(n);
    chk("rst_after_low", n, 5);
    run_phase(n);
    chk("rst_after_high", n, 5);

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    tick(0, 0, 0, 1);
    chk("edge_cnt_reset", edge_cnt, 0);
    tick(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) run_phase(n);
    chk("edge_cnt_three", edge_cnt, 3);
    tick(0, 0, 0, 1);
    chk("edge_cnt_cleared", edge_cnt, 0);
`endif

    // randomized traffic, compared every cycle against the model
    tick(0, 0, 0, 1);
    e_r = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) e_r = 1 - e_r;
      tick(e_r,
           ($urandom_range(0, 5) == 0) ? 1 : 0,
           int'($urandom_range(0, 6)),
           ($urandom_range(0, 199) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
